// File: rtl/tcp_tx_chan_mux.sv
// Multi-channel TX front end for SiTCP: per-channel FIFOs, round-robin grant,
// and framing of each grant into a byte stream paced by TCP_TX_FULL.
module tcp_tx_chan_mux #(
    parameter int NCH      = 4,
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 512,
    parameter int BURST    = 64,
    parameter int PFULL_TH = 496
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    FLUSH,
    input  logic [NCH-1:0]          CH_ENABLE,
    input  logic [NCH-1:0]          CH_WE,
    input  logic [NCH*DATA_W-1:0]   CH_DATA,
    output logic [NCH-1:0]          CH_PFULL,
    output logic [NCH-1:0]          CH_OVF,
    input  logic                    TCP_TX_FULL,
    output logic                    TCP_TX_WR,
    output logic [7:0]              TCP_TX_DATA
);

    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int NB  = DATA_W / 8;
    localparam int BW  = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR0 = 2'd1,
        ST_HDR1 = 2'd2,
        ST_DATA = 2'd3
    } state_t;

    // Round-robin search starting just after the last granted channel.
    // Result MSB flags a hit, low bits carry the channel.
    function automatic logic [CHW:0] rr_pick(input logic [NCH-1:0] req,
                                             input logic [CHW-1:0] last);
        logic [CHW:0] res;
        int idx;
        res = {(CHW+1){1'b0}};
        for (int k = 1; k <= NCH; k++) begin
            idx = (int'(last) + k) % NCH;
            if (!res[CHW] && req[idx]) begin
                res = {1'b1, CHW'(idx)};
            end
        end
        return res;
    endfunction

    logic [CW-1:0]      cnt_s   [NCH];
    logic [DATA_W-1:0]  head_s  [NCH];
    logic [NCH-1:0]     ne_s;
    logic [NCH-1:0]     nz_s;
    logic [NCH-1:0]     pop_s;
    logic [NCH-1:0]     elig_s;

    state_t             state_r, state_s;
    logic [CHW-1:0]     ch_r, ch_s;
    logic [CHW-1:0]     last_grant_r, last_grant_s;
    logic [7:0]         n_r, n_s;
    logic [7:0]         word_idx_r, word_idx_s;
    logic [BW-1:0]      byte_idx_r, byte_idx_s;
    logic               tx_wr_r, tx_wr_s;
    logic [7:0]         tx_data_r, tx_data_s;

    logic [CHW:0]       pick_s;
    logic [CW-1:0]      gcnt_s;
    logic [DATA_W-1:0]  head_word_s;
    logic [DATA_W-1:0]  byte_sh_s;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        logic [DATA_W-1:0] mem_r [DEPTH];
        logic [AW-1:0]     wr_ptr_r;
        logic [AW-1:0]     rd_ptr_r;
        logic [CW-1:0]     cnt_r;
        logic              ne_r;
        logic              pfull_r;
        logic              ovf_r;
        logic              accept_s;

        // A full FIFO refuses the write even if the head is popped this cycle.
        assign accept_s = CH_WE[gi] && (cnt_r != CW'(DEPTH)) && !FLUSH;

        // Word storage; contents need no reset since occupancy gates every read.
        always_ff @(posedge CLK) begin
            if (accept_s) begin
                mem_r[wr_ptr_r] <= CH_DATA[gi*DATA_W +: DATA_W];
            end
        end

        // Pointers, occupancy and the registered status flags.
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                wr_ptr_r <= {AW{1'b0}};
                rd_ptr_r <= {AW{1'b0}};
                cnt_r    <= {CW{1'b0}};
                ne_r     <= 1'b0;
                pfull_r  <= 1'b0;
                ovf_r    <= 1'b0;
            end else if (FLUSH) begin
                wr_ptr_r <= {AW{1'b0}};
                rd_ptr_r <= {AW{1'b0}};
                cnt_r    <= {CW{1'b0}};
                ne_r     <= 1'b0;
                pfull_r  <= 1'b0;
                ovf_r    <= 1'b0;
            end else begin
                if (accept_s) begin
                    wr_ptr_r <= wr_ptr_r + AW'(1'b1);
                end
                if (pop_s[gi]) begin
                    rd_ptr_r <= rd_ptr_r + AW'(1'b1);
                end
                case ({accept_s, pop_s[gi]})
                    2'b10:   cnt_r <= cnt_r + CW'(1'b1);
                    2'b01:   cnt_r <= cnt_r - CW'(1'b1);
                    default: cnt_r <= cnt_r;
                endcase
                if (CH_WE[gi] && !accept_s) begin
                    ovf_r <= 1'b1;
                end
                ne_r    <= (cnt_r != {CW{1'b0}});
                pfull_r <= (cnt_r >= CW'(PFULL_TH));
            end
        end

        assign cnt_s[gi]    = cnt_r;
        assign head_s[gi]   = mem_r[rd_ptr_r];
        assign ne_s[gi]     = ne_r;
        assign nz_s[gi]     = (cnt_r != {CW{1'b0}});
        assign CH_PFULL[gi] = pfull_r;
        assign CH_OVF[gi]   = ovf_r;
    end

    // The registered non-empty flag delays eligibility by one cycle, which sets
    // the write-to-HDR0 latency; the live count guards against a stale flag after a pop.
    assign elig_s      = CH_ENABLE & ne_s & nz_s;
    assign pick_s      = rr_pick(elig_s, last_grant_r);
    assign gcnt_s      = cnt_s[pick_s[CHW-1:0]];
    assign head_word_s = head_s[ch_r];
    assign byte_sh_s   = head_word_s >> (8 * (NB - 1 - int'(byte_idx_r)));

    // Frame sequencer: next state, byte selection and head-of-FIFO pops.
    always_comb begin
        state_s      = state_r;
        ch_s         = ch_r;
        n_s          = n_r;
        word_idx_s   = word_idx_r;
        byte_idx_s   = byte_idx_r;
        last_grant_s = last_grant_r;
        tx_wr_s      = 1'b0;
        tx_data_s    = tx_data_r;
        pop_s        = {NCH{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (pick_s[CHW]) begin
                    ch_s         = pick_s[CHW-1:0];
                    last_grant_s = pick_s[CHW-1:0];
                    n_s          = (int'(gcnt_s) > BURST) ? 8'(BURST) : 8'(gcnt_s);
                    word_idx_s   = 8'd0;
                    byte_idx_s   = {BW{1'b0}};
                    state_s      = ST_HDR0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_HDR0: begin
                if (!TCP_TX_FULL) begin
                    tx_wr_s   = 1'b1;
                    tx_data_s = {4'hA, 4'(ch_r)};
                    state_s   = ST_HDR1;
                end else begin
                    state_s = ST_HDR0;
                end
            end
            ST_HDR1: begin
                if (!TCP_TX_FULL) begin
                    tx_wr_s   = 1'b1;
                    tx_data_s = n_r;
                    state_s   = ST_DATA;
                end else begin
                    state_s = ST_HDR1;
                end
            end
            ST_DATA: begin
                if (!TCP_TX_FULL) begin
                    tx_wr_s   = 1'b1;
                    tx_data_s = byte_sh_s[7:0];
                    if (byte_idx_r == BW'(NB - 1)) begin
                        pop_s[ch_r] = 1'b1;
                        byte_idx_s  = {BW{1'b0}};
                        if (word_idx_r == n_r - 8'd1) begin
                            state_s = ST_IDLE;
                        end else begin
                            word_idx_s = word_idx_r + 8'd1;
                        end
                    end else begin
                        byte_idx_s = byte_idx_r + BW'(1'b1);
                    end
                end else begin
                    state_s = ST_DATA;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Sequencer registers and the registered SiTCP byte interface.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r      <= ST_IDLE;
            ch_r         <= {CHW{1'b0}};
            last_grant_r <= CHW'(NCH - 1);
            n_r          <= 8'd0;
            word_idx_r   <= 8'd0;
            byte_idx_r   <= {BW{1'b0}};
            tx_wr_r      <= 1'b0;
            tx_data_r    <= 8'h00;
        end else if (FLUSH) begin
            state_r      <= ST_IDLE;
            ch_r         <= {CHW{1'b0}};
            last_grant_r <= CHW'(NCH - 1);
            n_r          <= 8'd0;
            word_idx_r   <= 8'd0;
            byte_idx_r   <= {BW{1'b0}};
            tx_wr_r      <= 1'b0;
            tx_data_r    <= tx_data_r;
        end else begin
            state_r      <= state_s;
            ch_r         <= ch_s;
            last_grant_r <= last_grant_s;
            n_r          <= n_s;
            word_idx_r   <= word_idx_s;
            byte_idx_r   <= byte_idx_s;
            tx_wr_r      <= tx_wr_s;
            tx_data_r    <= tx_data_s;
        end
    end

    assign TCP_TX_WR   = tx_wr_r;
    assign TCP_TX_DATA = tx_data_r;

endmodule

// File: tb/tb_tcp_tx_chan_mux.sv
// Directed bench for tcp_tx_chan_mux: framing, round-robin order, burst split,
// backpressure, FIFO full/overflow and flush, with hand-built expected streams.
module tb_tcp_tx_chan_mux;

    localparam int NCH = 4;
    localparam int DW  = 32;

    logic              CLK;
    logic              RST;
    logic              FLUSH;
    logic [NCH-1:0]    CH_ENABLE;
    logic [NCH-1:0]    CH_WE;
    logic [NCH*DW-1:0] CH_DATA;
    logic [NCH-1:0]    CH_PFULL;
    logic [NCH-1:0]    CH_OVF;
    logic              TCP_TX_FULL;
    logic              TCP_TX_WR;
    logic [7:0]        TCP_TX_DATA;

    int test_cnt = 0;
    int fail_cnt = 0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    tcp_tx_chan_mux #(
        .NCH(4), .DATA_W(32), .DEPTH(512), .BURST(64), .PFULL_TH(496)
    ) dut (
        .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
        .CH_ENABLE(CH_ENABLE), .CH_WE(CH_WE), .CH_DATA(CH_DATA),
        .CH_PFULL(CH_PFULL), .CH_OVF(CH_OVF),
        .TCP_TX_FULL(TCP_TX_FULL), .TCP_TX_WR(TCP_TX_WR), .TCP_TX_DATA(TCP_TX_DATA)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Byte collector, sampled on the inactive edge.
    always @(negedge CLK) begin
        if (TCP_TX_WR === 1'b1) rx_q.push_back(TCP_TX_DATA);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        test_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_hdr(input int ch, input int n);
        exp_q.push_back(8'hA0 | 8'(ch));
        exp_q.push_back(8'(n));
    endtask

    task automatic push_word(input logic [31:0] w);
        exp_q.push_back(w[31:24]);
        exp_q.push_back(w[23:16]);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[7:0]);
    endtask

    task automatic wait_bytes(input int n, input int budget);
        int k;
        k = 0;
        while (rx_q.size() < n && k < budget) begin
            @(posedge CLK);
            k++;
        end
        repeat (12) @(posedge CLK);
        #1;
    endtask

    // Length check, then byte-by-byte until the first difference.
    task automatic chk_stream(input string tag);
        chk({tag, "_len"}, 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            chk({tag, "_byte"}, {24'h0, rx_q[i]}, {24'h0, exp_q[i]});
            if (rx_q[i] !== exp_q[i]) break;
        end
    endtask

    task automatic write1(input int ch, input logic [31:0] d);
        @(negedge CLK);
        CH_WE = 4'b0001 << ch;
        CH_DATA[ch*DW +: DW] = d;
        @(negedge CLK);
        CH_WE = 4'b0000;
    endtask

    function automatic logic [31:0] t2w(input int c, input int k);
        return 32'hC0D0_0000 + 32'(c * 256 + k);
    endfunction

    initial begin
        int seen;
        int k;
        RST = 1'b1;
        FLUSH = 1'b0;
        CH_ENABLE = 4'b0000;
        CH_WE = 4'b0000;
        CH_DATA = {(NCH*DW){1'b0}};
        TCP_TX_FULL = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_wr", {31'h0, TCP_TX_WR}, 32'h0);
        chk("rst_data", {24'h0, TCP_TX_DATA}, 32'h0);
        chk("rst_pfull", {28'h0, CH_PFULL}, 32'h0);
        chk("rst_ovf", {28'h0, CH_OVF}, 32'h0);
        @(negedge CLK);
        RST = 1'b0;
        CH_ENABLE = 4'b1111;

        // 1: single word on ch2, latency and framing
        rx_q.delete(); exp_q.delete();
        @(negedge CLK);
        CH_WE = 4'b0100;
        CH_DATA[2*DW +: DW] = 32'h1122_3344;
        @(posedge CLK); #1;
        CH_WE = 4'b0000;
        @(posedge CLK); #1;
        chk("t1_lat_e1", {31'h0, TCP_TX_WR}, 32'h0);
        @(posedge CLK); #1;
        chk("t1_lat_e2", {31'h0, TCP_TX_WR}, 32'h0);
        @(posedge CLK); #1;
        chk("t1_lat_e3_wr", {31'h0, TCP_TX_WR}, 32'h1);
        chk("t1_lat_e3_data", {24'h0, TCP_TX_DATA}, 32'hA2);
        push_hdr(2, 1); push_word(32'h1122_3344);
        wait_bytes(6, 50);
        chk_stream("t1");

        // 2: round robin over four channels plus a late ch0 word
        @(negedge CLK); FLUSH = 1'b1; CH_ENABLE = 4'b0000;
        @(negedge CLK); FLUSH = 1'b0;
        rx_q.delete(); exp_q.delete();
        for (int w = 0; w < 3; w++) begin
            @(negedge CLK);
            CH_WE = 4'b1111;
            for (int c = 0; c < NCH; c++) CH_DATA[c*DW +: DW] = t2w(c, w);
        end
        @(negedge CLK);
        CH_WE = 4'b0000;
        CH_ENABLE = 4'b1111;
        k = 0;
        while (rx_q.size() < 16 && k < 100) begin
            @(posedge CLK); k++;
        end
        write1(0, t2w(0, 9));
        for (int c = 0; c < NCH; c++) begin
            push_hdr(c, 3);
            for (int w = 0; w < 3; w++) push_word(t2w(c, w));
        end
        push_hdr(0, 1); push_word(t2w(0, 9));
        wait_bytes(62, 200);
        chk_stream("t2");

        // 3: 100 words on ch1 split by BURST
        rx_q.delete(); exp_q.delete();
        CH_ENABLE = 4'b0000;
        for (int w = 0; w < 100; w++) begin
            @(negedge CLK);
            CH_WE = 4'b0010;
            CH_DATA[1*DW +: DW] = 32'h1357_0000 + 32'(w);
        end
        @(negedge CLK);
        CH_WE = 4'b0000;
        CH_ENABLE = 4'b0010;
        push_hdr(1, 64);
        for (int w = 0; w < 64; w++) push_word(32'h1357_0000 + 32'(w));
        push_hdr(1, 36);
        for (int w = 64; w < 100; w++) push_word(32'h1357_0000 + 32'(w));
        wait_bytes(404, 1000);
        chk_stream("t3");

        // 4: backpressure for 5 cycles mid-word
        rx_q.delete(); exp_q.delete();
        CH_ENABLE = 4'b0000;
        write1(0, 32'h4142_4344);
        write1(0, 32'h4546_4748);
        @(posedge CLK); #1;
        CH_ENABLE = 4'b0001;
        seen = 0; k = 0;
        while (seen < 4 && k < 50) begin
            @(posedge CLK); #1;
            if (TCP_TX_WR === 1'b1) seen++;
            k++;
        end
        chk("t4_reach", 32'(seen), 32'd4);
        TCP_TX_FULL = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(posedge CLK); #1;
            chk("t4_hold_wr", {31'h0, TCP_TX_WR}, 32'h0);
        end
        TCP_TX_FULL = 1'b0;
        @(posedge CLK); #1;
        chk("t4_resume_wr", {31'h0, TCP_TX_WR}, 32'h1);
        chk("t4_resume_data", {24'h0, TCP_TX_DATA}, 32'h43);
        push_hdr(0, 2); push_word(32'h4142_4344); push_word(32'h4546_4748);
        wait_bytes(10, 50);
        chk_stream("t4");

        // 5: fill ch3, prog-full threshold and overflow
        rx_q.delete(); exp_q.delete();
        CH_ENABLE = 4'b0000;
        for (int w = 0; w < 495; w++) begin
            @(negedge CLK); CH_WE = 4'b1000; CH_DATA[3*DW +: DW] = 32'h3000_0000 + 32'(w);
        end
        @(negedge CLK); CH_WE = 4'b0000;
        repeat (2) @(negedge CLK);
        chk("t5_pfull_495", {28'h0, CH_PFULL}, 32'h0);
        write1(3, 32'h3000_0000 + 32'd495);
        repeat (2) @(negedge CLK);
        chk("t5_pfull_496", {28'h0, CH_PFULL}, 32'h8);
        for (int w = 496; w < 512; w++) begin
            @(negedge CLK); CH_WE = 4'b1000; CH_DATA[3*DW +: DW] = 32'h3000_0000 + 32'(w);
        end
        @(negedge CLK); CH_WE = 4'b0000;
        @(negedge CLK);
        chk("t5_ovf_at_512", {28'h0, CH_OVF}, 32'h0);
        write1(3, 32'hDEAD_0001);
        write1(3, 32'hDEAD_0002);
        @(negedge CLK);
        chk("t5_ovf_set", {28'h0, CH_OVF}, 32'h8);
        CH_ENABLE = 4'b1000;
        for (int f = 0; f < 8; f++) begin
            push_hdr(3, 64);
            for (int w = 0; w < 64; w++) push_word(32'h3000_0000 + 32'(f * 64 + w));
        end
        wait_bytes(2064, 4000);
        chk_stream("t5");
        chk("t5_ovf_sticky", {28'h0, CH_OVF}, 32'h8);
        chk("t5_pfull_drained", {28'h0, CH_PFULL}, 32'h0);

        // 6: flush mid-frame with ch1 pending, then a fresh ch1 word
        rx_q.delete(); exp_q.delete();
        CH_ENABLE = 4'b0000;
        for (int w = 0; w < 4; w++) begin
            @(negedge CLK);
            CH_WE = (w < 2) ? 4'b0011 : 4'b0001;
            CH_DATA[0*DW +: DW] = 32'h6000_0000 + 32'(w);
            CH_DATA[1*DW +: DW] = 32'h6100_0000 + 32'(w);
        end
        @(negedge CLK);
        CH_WE = 4'b0000;
        @(posedge CLK); #1;
        CH_ENABLE = 4'b1111;
        seen = 0; k = 0;
        while (seen < 5 && k < 50) begin
            @(posedge CLK); #1;
            if (TCP_TX_WR === 1'b1) seen++;
            k++;
        end
        chk("t6_reach", 32'(seen), 32'd5);
        FLUSH = 1'b1;
        CH_WE = 4'b0100;
        CH_DATA[2*DW +: DW] = 32'hBAD0_BAD0;
        @(posedge CLK); #1;
        FLUSH = 1'b0;
        CH_WE = 4'b0000;
        chk("t6_flush_wr", {31'h0, TCP_TX_WR}, 32'h0);
        chk("t6_flush_ovf", {28'h0, CH_OVF}, 32'h0);
        rx_q.delete();
        repeat (20) @(posedge CLK);
        #1;
        chk("t6_quiet", 32'(rx_q.size()), 32'd0);
        chk("t6_ovf_after", {28'h0, CH_OVF}, 32'h0);
        write1(1, 32'hCAFE_F00D);
        push_hdr(1, 1); push_word(32'hCAFE_F00D);
        wait_bytes(6, 50);
        chk_stream("t6");

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
